// File: rtl/tw_mult_st1.sv
// tw_mult_st1: complex twiddle multiplier between the stage-1 butterfly and
// the next FFT stage. Each accepted sample x gets an index k (0..7) within
// its 8-sample group and leaves as sat(round(x * W16^k)). The twiddle comes
// from an external registered ROM that this block addresses via tw_addr.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready drops only while the
//                       output beat is held by downstream
//   in_first            marks sample k=0 of a group (qualified by in_valid)
//   in_re/in_im         signed DW-bit complex sample
//   tw_addr             ROM address (k); combinational
//   tw_re/tw_im         signed Q1.(TW-1) twiddle, one cycle after tw_addr
//   out_valid/out_ready output handshake
//   out_re/out_im       signed DW-bit product, rounded and saturated
//   out_last            output beat is k=7 of its group
//
// Pipeline: s1 (sample + k) -> s2 (four partial products) -> output
// (combine, round, saturate). Latency 3, one beat per cycle, the whole
// pipeline freezes while the output beat is stalled.

module tw_mult_st1 #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic [2:0]           tw_addr,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last
);

  localparam int unsigned PW   = DW + TW;      // partial product width
  localparam int unsigned SW   = PW + 1;       // combined sum width
  localparam int unsigned FRAC = TW - 1;       // twiddle fraction bits
  localparam int unsigned RW   = SW - FRAC;    // width after rescaling
  localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC - 1));
  localparam logic [2:0] LAST_K = 3'd7;

  // Control
  logic       stall;
  logic       accept;
  logic [2:0] wr_idx;
  logic [2:0] cur_k;

  // Stage s1: accepted sample and its index
  logic                 s1_valid;
  logic signed [DW-1:0] s1_re;
  logic signed [DW-1:0] s1_im;
  logic [2:0]           s1_idx;

  // Stage s2: partial products
  logic                 s2_valid;
  logic                 s2_last;
  logic signed [PW-1:0] p_rr;
  logic signed [PW-1:0] p_ii;
  logic signed [PW-1:0] p_ri;
  logic signed [PW-1:0] p_ir;

  // Output-stage combinational datapath
  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;
  logic signed [RW-1:0] scl_re;
  logic signed [RW-1:0] scl_im;
  logic signed [DW-1:0] res_re;
  logic signed [DW-1:0] res_im;

  // Clamp a rescaled value into the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat(input logic signed [RW-1:0] x);
    if (x[RW-1:DW-1] == {(RW-DW+1){x[DW-1]}}) begin
      return x[DW-1:0];
    end else if (x[RW-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  // Handshake: reset overrides a pending stall so the input is never blocked
  // across reset.
  assign stall    = out_valid & ~out_ready & ~rst;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign cur_k    = in_first ? 3'd0 : wr_idx;

  // While stalled, keep the ROM pointed at the held s1 sample so the twiddle
  // it needs is still on tw_re/tw_im in the cycle the stall releases.
  assign tw_addr = (stall && s1_valid) ? s1_idx : cur_k;

  // Combine products, round half-up, rescale and saturate.
  always_comb begin
    sum_re = SW'(p_rr) - SW'(p_ii);
    sum_im = SW'(p_ri) + SW'(p_ir);
    scl_re = RW'((sum_re + RND) >>> FRAC);
    scl_im = RW'((sum_im + RND) >>> FRAC);
    res_re = sat(scl_re);
    res_im = sat(scl_im);
  end

  // Group index counter: advances only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= 3'd0;
    end else if (accept) begin
      wr_idx <= cur_k + 3'd1;
    end
  end

  // Stage s1: valid always follows the input; data only loads on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_re  <= in_re;
        s1_im  <= in_im;
        s1_idx <= cur_k;
      end
    end
  end

  // Stage s2: products of the s1 sample with the twiddle now on the ROM bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= (s1_idx == LAST_K);
        p_rr    <= PW'(s1_re) * PW'(tw_re);
        p_ii    <= PW'(s1_im) * PW'(tw_im);
        p_ri    <= PW'(s1_re) * PW'(tw_im);
        p_ir    <= PW'(s1_im) * PW'(tw_re);
      end
    end
  end

  // Output register: holds across a stall; bubbles clear valid and last.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      out_last  <= s2_valid & s2_last;
      if (s2_valid) begin
        out_re <= res_re;
        out_im <= res_im;
      end
    end
  end

endmodule
